// File: rtl/roc_pkg.sv
// rtl/roc_pkg.sv - shared constants and FSM state type for the ROC readout emulator
package roc_pkg;
  localparam logic [8:0] ROC_HDR_PREFIX = 9'b011111111;
  localparam int         HDR_LEN        = 12;
  localparam int         HIT_LEN        = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_HIT,
    ST_TOKEN
  } tx_state_t;
endpackage

// File: rtl/hit_fifo.sv
// rtl/hit_fifo.sv - synchronous hit-word FIFO with full flag and occupancy count
module hit_fifo #(
  parameter int MAX_HITS = 16,
  parameter int HCW      = 5,
  parameter int DW       = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic [HCW-1:0] count
);
  localparam int AW = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1;

  logic [DW-1:0] mem [MAX_HITS];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_HITS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == HCW'(MAX_HITS));
  assign push    = wr_en && !full;
  assign pop     = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/roc_data_tx.sv
// rtl/roc_data_tx.sv - serial ROC frame transmitter: header, preloaded hits, token-out pulse
module roc_data_tx
  import roc_pkg::*;
#(
  parameter int MAX_HITS = 16,
  parameter int HCW      = $clog2(MAX_HITS + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic [2:0]     header_lsb,
  input  logic           hit_write,
  input  logic [23:0]    hit_data,
  output logic           hit_full,
  output logic [HCW-1:0] hit_count,
  input  logic           trigger,
  output logic           sdata,
  output logic           busy,
  output logic           tok_out,
  output logic [7:0]     missed_trig
);
  tx_state_t            state_q, state_d;
  logic [HIT_LEN-1:0]   shreg_q, shreg_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [HCW-1:0]       hit_cnt_q, hit_cnt_d;
  logic [HIT_LEN-1:0]   fifo_data;
  logic                 pop;
  logic                 accept;
  logic                 seg_end;

  hit_fifo #(.MAX_HITS(MAX_HITS), .HCW(HCW), .DW(HIT_LEN)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (hit_write),
    .wr_data (hit_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (hit_full),
    .count   (hit_count)
  );

  assign sdata  = shreg_q[HIT_LEN-1];
  assign accept = trigger && enable && (state_q == ST_IDLE);

  // hit_cnt holds the number of hits still to send after the current segment
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    hit_cnt_d = hit_cnt_q;
    pop       = 1'b0;
    busy      = 1'b0;
    tok_out   = 1'b0;
    seg_end   = (state_q == ST_HEADER) ? (bit_cnt_q == 5'(HDR_LEN - 1))
                                       : (bit_cnt_q == 5'(HIT_LEN - 1));
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_HEADER;
          shreg_d   = {ROC_HDR_PREFIX, header_lsb, {(HIT_LEN - HDR_LEN){1'b0}}};
          bit_cnt_d = '0;
          hit_cnt_d = hit_count;
        end
      end
      ST_HEADER, ST_HIT: begin
        busy      = 1'b1;
        shreg_d   = {shreg_q[HIT_LEN-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (seg_end) begin
          bit_cnt_d = '0;
          if (hit_cnt_q == '0) begin
            state_d = ST_TOKEN;
            shreg_d = '0;
          end else begin
            state_d   = ST_HIT;
            pop       = 1'b1;
            shreg_d   = fifo_data;
            hit_cnt_d = hit_cnt_q - 1'b1;
          end
        end
      end
      ST_TOKEN: begin
        tok_out = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort: drop straight to idle; words already popped are lost
    if (!enable && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      missed_trig <= '0;
    end else if (trigger && !accept && missed_trig != 8'hFF) begin
      missed_trig <= missed_trig + 8'd1;
    end
  end
endmodule

// File: tb/tb_roc_data_tx.sv
// tb/tb_roc_data_tx.sv - directed scoreboard bench for roc_data_tx
module tb_roc_data_tx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  header_lsb;
  logic        hit_write;
  logic [23:0] hit_data;
  logic        hit_full;
  logic [4:0]  hit_count;
  logic        trigger;
  logic        sdata;
  logic        busy;
  logic        tok_out;
  logic [7:0]  missed_trig;

  int          n_vec = 0;
  int          n_err = 0;
  int          busy_cnt = 0;
  logic        exp_q[$];
  logic [23:0] model_q[$];
  logic        b;

  roc_data_tx #(.MAX_HITS(16), .HCW(5)) dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .enable      (enable),
    .header_lsb  (header_lsb),
    .hit_write   (hit_write),
    .hit_data    (hit_data),
    .hit_full    (hit_full),
    .hit_count   (hit_count),
    .trigger     (trigger),
    .sdata       (sdata),
    .busy        (busy),
    .tok_out     (tok_out),
    .missed_trig (missed_trig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial bit scoreboard: every busy cycle consumes one expected bit
  always @(negedge clk) begin
    if (rst_n === 1'b1 && busy === 1'b1) begin
      busy_cnt++;
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL extra_bit: observed sdata %0b expected no frame bit", sdata);
      end
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        assert (sdata === b) else begin
          n_err++;
          $error("FAIL sdata: observed %0b expected %0b (bit %0d)", sdata, b, busy_cnt - 1);
        end
      end
    end
  end

  task automatic push(input logic [23:0] w);
    hit_write = 1'b1;
    hit_data  = w;
    if (model_q.size() < 16) model_q.push_back(w);
    @(negedge clk);
    hit_write = 1'b0;
  endtask

  task automatic trig(input logic [2:0] h, input bit with_push, input logic [23:0] pw);
    logic [11:0] hdr;
    logic [23:0] w;
    int          n;
    hdr = {9'b011111111, h};
    n   = model_q.size();
    for (int i = 11; i >= 0; i--) exp_q.push_back(hdr[i]);
    for (int k = 0; k < n; k++) begin
      w = model_q.pop_front();
      for (int i = 23; i >= 0; i--) exp_q.push_back(w[i]);
    end
    if (with_push) begin
      hit_write = 1'b1;
      hit_data  = pw;
      if (model_q.size() < 16) model_q.push_back(pw);
    end
    busy_cnt   = 0;
    header_lsb = h;
    trigger    = 1'b1;
    @(negedge clk);
    trigger   = 1'b0;
    hit_write = 1'b0;
  endtask

  task automatic wait_frame(input int n);
    int guard = 0;
    while (tok_out !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("tok_seen", 32'(tok_out), 32'd1);
    chk("busy_len", busy_cnt, 12 + 24 * n);
    chk("busy_at_tok", 32'(busy), 32'd0);
    chk("sdata_at_tok", 32'(sdata), 32'd0);
    chk("bits_left", exp_q.size(), 32'd0);
    @(negedge clk);
    chk("tok_pulse_end", 32'(tok_out), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; header_lsb = '0; hit_write = 1'b0;
    hit_data = '0; trigger = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tok", 32'(tok_out), 32'd0);
    chk("rst_missed", 32'(missed_trig), 32'd0);
    chk("rst_count", 32'(hit_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty frame: header only, then token
    trig(3'b101, 1'b0, '0);
    wait_frame(0);

    // Two hits
    push(24'hABCDEF);
    push(24'h123456);
    chk("count_2", 32'(hit_count), 32'd2);
    trig(3'b010, 1'b0, '0);
    wait_frame(2);
    chk("count_after_2", 32'(hit_count), 32'd0);

    // Overfill: 17th word dropped
    for (int i = 0; i < 17; i++) push(24'h5A0000 + 24'(i * 24'h010203));
    chk("full_flag", 32'(hit_full), 32'd1);
    chk("count_16", 32'(hit_count), 32'd16);
    trig(3'b111, 1'b0, '0);
    wait_frame(16);
    chk("count_after_16", 32'(hit_count), 32'd0);
    chk("full_after_16", 32'(hit_full), 32'd0);

    // Push in the trigger cycle goes to the next frame
    push(24'h0F0F0F);
    trig(3'b000, 1'b1, 24'hF0F0F0);
    chk("count_snap", 32'(hit_count), 32'd2);
    wait_frame(1);
    chk("count_next", 32'(hit_count), 32'd1);
    trig(3'b001, 1'b0, '0);
    wait_frame(1);
    chk("count_drained", 32'(hit_count), 32'd0);

    // Rejected trigger while busy, then saturation
    trig(3'b100, 1'b0, '0);
    repeat (4) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    wait_frame(0);
    chk("missed_1", 32'(missed_trig), 32'd1);
    enable  = 1'b0;
    trigger = 1'b1;
    repeat (256) @(negedge clk);
    trigger = 1'b0;
    enable  = 1'b1;
    @(negedge clk);
    chk("missed_sat", 32'(missed_trig), 32'd255);

    // Abort at frame bit 30
    push(24'h111111);
    push(24'h222222);
    push(24'h333333);
    trig(3'b110, 1'b0, '0);
    repeat (30) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_sdata", 32'(sdata), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tok", 32'(tok_out), 32'd0);
    chk("abort_bits_sent", exp_q.size(), 32'd53);
    exp_q.delete();
    model_q.delete();
    model_q.push_back(24'h222222);
    model_q.push_back(24'h333333);
    chk("abort_count", 32'(hit_count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_tok", 32'(tok_out), 32'd0);
    end
    enable = 1'b1;
    trig(3'b000, 1'b0, '0);
    wait_frame(2);

    // Asynchronous reset mid-frame
    push(24'hC0FFEE);
    trig(3'b011, 1'b0, '0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sdata", 32'(sdata), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tok", 32'(tok_out), 32'd0);
    chk("arst_count", 32'(hit_count), 32'd0);
    chk("arst_missed", 32'(missed_trig), 32'd0);
    exp_q.delete();
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
